// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// The control field is zeroed whenever the stage is empty, so a bubble acts as a NOP downstream.
module pipe_stage_skid #(
   parameter int CTRL_W     = 11,
   parameter int DATA_W     = 143,
   parameter int CLEAR_DATA = 0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              r,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [CTRL_W-1:0]   main_ctrl_r, main_ctrl_s;
   logic [DATA_W-1:0]   main_data_r, main_data_s;
   logic [CTRL_W-1:0]   skid_ctrl_r, skid_ctrl_s;
   logic [DATA_W-1:0]   skid_data_r, skid_data_s;
   logic [CNT_W-1:0]    stall_cnt_r, stall_cnt_s;
   logic                in_ready_s, out_valid_s, in_fire_s, out_fire_s;

   // Handshake flags decode from the state register only, so ready never sees out_ready.
   assign in_ready_s  = (state_r != ST_FULL);
   assign out_valid_s = (state_r != ST_EMPTY);
   assign in_fire_s   = in_valid & in_ready_s;
   assign out_fire_s  = out_valid_s & out_ready;

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out_ctrl  = main_ctrl_r;
   assign out_data  = main_data_r;
   assign occupancy = state_r;
   assign stall_cnt = stall_cnt_r;

   // Next-state and next-payload selection for the main/skid entries and the stall counter.
   always_comb begin
      state_s     = state_r;
      main_ctrl_s = main_ctrl_r;
      main_data_s = main_data_r;
      skid_ctrl_s = skid_ctrl_r;
      skid_data_s = skid_data_r;
      stall_cnt_s = stall_cnt_r;

      if (flush) begin
         state_s     = ST_EMPTY;
         main_ctrl_s = {CTRL_W{1'b0}};
         skid_ctrl_s = {CTRL_W{1'b0}};
         if (CLEAR_DATA != 0) begin
            main_data_s = {DATA_W{1'b0}};
            skid_data_s = {DATA_W{1'b0}};
         end else begin
            main_data_s = main_data_r;
            skid_data_s = skid_data_r;
         end
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (in_fire_s) begin
                  state_s     = ST_ONE;
                  main_ctrl_s = in_ctrl;
                  main_data_s = in_data;
               end else begin
                  state_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire_s && out_fire_s) begin
                  main_ctrl_s = in_ctrl;
                  main_data_s = in_data;
               end else if (in_fire_s) begin
                  state_s     = ST_FULL;
                  skid_ctrl_s = in_ctrl;
                  skid_data_s = in_data;
               end else if (out_fire_s) begin
                  state_s     = ST_EMPTY;
                  main_ctrl_s = {CTRL_W{1'b0}};
                  if (CLEAR_DATA != 0) begin
                     main_data_s = {DATA_W{1'b0}};
                  end else begin
                     main_data_s = main_data_r;
                  end
               end else begin
                  state_s = ST_ONE;
               end
            end
            ST_FULL: begin
               if (out_fire_s) begin
                  state_s     = ST_ONE;
                  main_ctrl_s = skid_ctrl_r;
                  main_data_s = skid_data_r;
                  skid_ctrl_s = {CTRL_W{1'b0}};
                  if (CLEAR_DATA != 0) begin
                     skid_data_s = {DATA_W{1'b0}};
                  end else begin
                     skid_data_s = skid_data_r;
                  end
               end else begin
                  state_s = ST_FULL;
               end
            end
            default: begin
               state_s     = ST_EMPTY;
               main_ctrl_s = {CTRL_W{1'b0}};
               skid_ctrl_s = {CTRL_W{1'b0}};
            end
         endcase
      end

      if (out_valid_s && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_s = stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_s = stall_cnt_r;
      end
   end

   // State and payload registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!r) begin
         state_r     <= ST_EMPTY;
         main_ctrl_r <= {CTRL_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
         stall_cnt_r <= {CNT_W{1'b0}};
         if (CLEAR_DATA != 0) begin
            main_data_r <= {DATA_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
         end else begin
            main_data_r <= main_data_r;
            skid_data_r <= skid_data_r;
         end
      end else begin
         state_r     <= state_s;
         main_ctrl_r <= main_ctrl_s;
         main_data_r <= main_data_s;
         skid_ctrl_r <= skid_ctrl_s;
         skid_data_r <= skid_data_s;
         stall_cnt_r <= stall_cnt_s;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed table-driven bench for pipe_stage_skid: one instance holds data on drain/flush,
// a second one clears data and uses a 4-bit stall counter for the saturation case.
module tb_pipe_stage_skid;

   localparam int CTRL_W = 11;
   localparam int DATA_W = 143;

   logic              clk = 1'b0;
   logic              r, flush, in_valid, out_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;

   logic              a_in_ready, a_out_valid;
   logic [CTRL_W-1:0] a_out_ctrl;
   logic [DATA_W-1:0] a_out_data;
   logic [1:0]        a_occ;
   logic [15:0]       a_stall;

   logic              c_in_ready, c_out_valid;
   logic [CTRL_W-1:0] c_out_ctrl;
   logic [DATA_W-1:0] c_out_data;
   logic [1:0]        c_occ;
   logic [3:0]        c_stall;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(0), .CNT_W(16)) dut (
      .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_stall));

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(1), .CNT_W(4)) dut_c (
      .clk(clk), .r(r), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occ), .stall_cnt(c_stall));

   typedef struct {
      logic        r, fl, iv, ordy;
      logic [15:0] d;
      logic        e_ov, e_ir;
      logic [1:0]  e_occ;
      logic [15:0] e_d;
      logic        chk_d;
      logic [15:0] e_st;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r_i, input logic fl, input logic iv, input logic ordy,
                               input logic [15:0] d, input logic e_ov, input logic e_ir,
                               input logic [1:0] e_occ, input logic [15:0] e_d,
                               input logic chk_d, input logic [15:0] e_st);
      vec_t v;
      v.r = r_i; v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ; v.e_d = e_d;
      v.chk_d = chk_d; v.e_st = e_st;
      return v;
   endfunction

   task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r_i, input logic fl, input logic iv, input logic ordy,
                        input logic [15:0] d);
      r         = r_i;
      flush     = fl;
      in_valid  = iv;
      out_ready = ordy;
      in_ctrl   = d[CTRL_W-1:0];
      in_data   = {{(DATA_W-16){1'b0}}, d};
      @(posedge clk);
      #1;
   endtask

   initial begin
      r = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;

      // reset with a beat presented (ctrl all ones)
      vq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h07FF, 1'b0, 1'b1, 2'd0, 16'h0, 1'b0, 16'd0));
      vq.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h07FF, 1'b0, 1'b1, 2'd0, 16'h0, 1'b0, 16'd0));
      // streaming 1..8, then drain
      for (int k = 1; k <= 8; k++)
         vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'(k), 1'b1, 1'b1, 2'd1, 16'(k), 1'b1, 16'd0));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 2'd0, 16'd8, 1'b1, 16'd0));
      // back-pressure A, B accepted, C held, then release in order
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h10, 1'b1, 1'b1, 2'd1, 16'h10, 1'b1, 16'd0));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h20, 1'b1, 1'b0, 2'd2, 16'h10, 1'b1, 16'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h30, 1'b1, 1'b0, 2'd2, 16'h10, 1'b1, 16'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h30, 1'b1, 1'b1, 2'd1, 16'h20, 1'b1, 16'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h30, 1'b1, 1'b1, 2'd1, 16'h30, 1'b1, 16'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 2'd0, 16'h30, 1'b1, 16'd2));
      // fill to FULL, flush with a beat offered; that beat must never appear
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h40, 1'b1, 1'b1, 2'd1, 16'h40, 1'b1, 16'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h50, 1'b1, 1'b0, 2'd2, 16'h40, 1'b1, 16'd3));
      vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h60, 1'b0, 1'b1, 2'd0, 16'h40, 1'b1, 16'd4));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 2'd0, 16'h40, 1'b1, 16'd4));
      // flush in ONE while downstream consumes and upstream offers
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h70, 1'b1, 1'b1, 2'd1, 16'h70, 1'b1, 16'd4));
      vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h80, 1'b0, 1'b1, 2'd0, 16'h70, 1'b1, 16'd4));
      // reset wins over flush and clears the counter
      vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 16'h90, 1'b0, 1'b1, 2'd0, 16'h0, 1'b0, 16'd0));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2'd0, 16'h0, 1'b0, 16'd0));

      @(negedge clk);
      for (int i = 0; i < vq.size(); i++) begin
         vec_t v;
         logic [CTRL_W-1:0] e_ctrl;
         v = vq[i];
         e_ctrl = v.e_ov ? v.e_d[CTRL_W-1:0] : {CTRL_W{1'b0}};
         drive(v.r, v.fl, v.iv, v.ordy, v.d);
         check($sformatf("v%0d_out_valid", i), DATA_W'(a_out_valid), DATA_W'(v.e_ov));
         check($sformatf("v%0d_in_ready", i), DATA_W'(a_in_ready), DATA_W'(v.e_ir));
         check($sformatf("v%0d_occupancy", i), DATA_W'(a_occ), DATA_W'(v.e_occ));
         check($sformatf("v%0d_out_ctrl", i), DATA_W'(a_out_ctrl), DATA_W'(e_ctrl));
         check($sformatf("v%0d_stall_cnt", i), DATA_W'(a_stall), DATA_W'(v.e_st));
         check($sformatf("v%0d_c_occupancy", i), DATA_W'(c_occ), DATA_W'(v.e_occ));
         check($sformatf("v%0d_c_out_ctrl", i), DATA_W'(c_out_ctrl), DATA_W'(e_ctrl));
         check($sformatf("v%0d_c_stall_cnt", i), DATA_W'(c_stall), DATA_W'(v.e_st[3:0]));
         check($sformatf("v%0d_c_out_data", i), c_out_data,
               v.e_ov ? DATA_W'(v.e_d) : {DATA_W{1'b0}});
         if (v.chk_d)
            check($sformatf("v%0d_out_data", i), a_out_data, DATA_W'(v.e_d));
      end

      // saturation: one beat held under back-pressure for 20 cycles
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h99);
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
         check($sformatf("sat%0d_stall_cnt", k), DATA_W'(a_stall), DATA_W'(k));
         check($sformatf("sat%0d_c_stall_cnt", k), DATA_W'(c_stall), DATA_W'((k > 15) ? 15 : k));
         check($sformatf("sat%0d_hold_data", k), a_out_data, DATA_W'(16'h99));
         check($sformatf("sat%0d_hold_valid", k), DATA_W'(c_out_valid), DATA_W'(1'b1));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      check("sat_reset_stall_cnt", DATA_W'(a_stall), DATA_W'(0));
      check("sat_reset_c_stall_cnt", DATA_W'(c_stall), DATA_W'(0));
      check("sat_reset_out_valid", DATA_W'(c_out_valid), DATA_W'(0));
      check("sat_reset_c_out_data", c_out_data, {DATA_W{1'b0}});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
